// File: rtl/rv32im_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32im_pkg
// Description : Shared definitions for the RV32IM multiply/divide issue logic:
//               M-extension funct3 encodings and the issue FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32im_pkg;

  localparam int FUNCT3_W = 3;

  // M-extension funct3 encodings
  localparam logic [FUNCT3_W-1:0] MUL    = 3'b000;
  localparam logic [FUNCT3_W-1:0] MULH   = 3'b001;
  localparam logic [FUNCT3_W-1:0] MULHSU = 3'b010;
  localparam logic [FUNCT3_W-1:0] MULHU  = 3'b011;
  localparam logic [FUNCT3_W-1:0] DIV    = 3'b100;
  localparam logic [FUNCT3_W-1:0] DIVU   = 3'b101;
  localparam logic [FUNCT3_W-1:0] REM    = 3'b110;
  localparam logic [FUNCT3_W-1:0] REMU   = 3'b111;

  // Issue sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_WRITE  = 2'd3
  } issue_state_e;

endpackage
`default_nettype wire

// File: rtl/rv32im_md_lastcache.sv
`default_nettype none
// ============================================================================
// Module      : rv32im_md_lastcache
// Description : One-entry last-result cache. Tag is funct3 plus both source
//               operands; a hit needs a valid entry and an exact tag match.
//               Only reset invalidates the entry.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32im_md_lastcache
  import rv32im_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  // lookup side (combinational compare against the incoming instruction)
  input  logic [FUNCT3_W-1:0] lookup_funct3_i,
  input  logic [XLEN-1:0]     lookup_rs1_i,
  input  logic [XLEN-1:0]     lookup_rs2_i,
  output logic                hit_o,
  output logic [XLEN-1:0]     data_o,
  // update side
  input  logic                upd_en_i,
  input  logic [FUNCT3_W-1:0] upd_funct3_i,
  input  logic [XLEN-1:0]     upd_rs1_i,
  input  logic [XLEN-1:0]     upd_rs2_i,
  input  logic [XLEN-1:0]     upd_data_i
);

  logic                valid_q;
  logic [FUNCT3_W-1:0] tag_f3_q;
  logic [XLEN-1:0]     tag_rs1_q;
  logic [XLEN-1:0]     tag_rs2_q;
  logic [XLEN-1:0]     data_q;

  // Entry storage: cleared by reset, overwritten on every update
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q   <= 1'b0;
      tag_f3_q  <= '0;
      tag_rs1_q <= '0;
      tag_rs2_q <= '0;
      data_q    <= '0;
    end else if (upd_en_i) begin
      valid_q   <= 1'b1;
      tag_f3_q  <= upd_funct3_i;
      tag_rs1_q <= upd_rs1_i;
      tag_rs2_q <= upd_rs2_i;
      data_q    <= upd_data_i;
    end
  end

  assign hit_o  = valid_q
                  && (tag_f3_q  == lookup_funct3_i)
                  && (tag_rs1_q == lookup_rs1_i)
                  && (tag_rs2_q == lookup_rs2_i);
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/rv32im_muldiv_issue.sv
`default_nettype none
// ============================================================================
// Module      : rv32im_muldiv_issue
// Description : Issue/writeback sequencer in front of rv32im_muldiv. Accepts
//               one M instruction at a time, launches it with a one-cycle
//               strobe, waits (with timeout) for the result and drives the
//               register-file write port. Repeated identical operations are
//               served from a one-entry last-result cache.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32im_muldiv_issue
  import rv32im_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 63
) (
  input  logic                clk_i,
  input  logic                reset_i,
  // decoder side
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [FUNCT3_W-1:0] funct3_i,
  input  logic [4:0]          rd_i,
  input  logic [XLEN-1:0]     rs1_val_i,
  input  logic [XLEN-1:0]     rs2_val_i,
  input  logic                flush_i,
  // muldiv unit side
  output logic [FUNCT3_W-1:0] md_operation_o,
  output logic [XLEN-1:0]     md_operand1_o,
  output logic [XLEN-1:0]     md_operand2_o,
  output logic                md_data_ready_o,
  output logic                md_clear_o,
  output logic                md_writeback_ce_o,
  input  logic [XLEN-1:0]     md_result_i,
  input  logic                md_data_ready_i,
  // register-file write port
  output logic                wb_valid_o,
  output logic [4:0]          wb_rd_o,
  output logic [XLEN-1:0]     wb_data_o,
  input  logic                wb_ack_i,
  // status
  output logic                stall_o,
  output logic                err_o
);

  localparam int             CNT_W     = 7;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  issue_state_e        state_q, state_d;

  logic [FUNCT3_W-1:0] funct3_q, funct3_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     op1_q, op1_d;
  logic [XLEN-1:0]     op2_q, op2_d;
  logic                strobe_q, strobe_d;
  logic                clear_q, clear_d;
  logic                wbce_q, wbce_d;
  logic                wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                cache_upd;
  logic                cache_hit;
  logic [XLEN-1:0]     cache_data;
  logic [CNT_W-1:0]    cnt_inc;

  // WAIT cycles elapsed including the current one
  assign cnt_inc = cnt_q + CNT_W'(1);

  rv32im_md_lastcache #(
    .XLEN (XLEN)
  ) u_lastcache (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .lookup_funct3_i (funct3_i),
    .lookup_rs1_i    (rs1_val_i),
    .lookup_rs2_i    (rs2_val_i),
    .hit_o           (cache_hit),
    .data_o          (cache_data),
    .upd_en_i        (cache_upd),
    .upd_funct3_i    (funct3_q),
    .upd_rs1_i       (op1_q),
    .upd_rs2_i       (op2_q),
    .upd_data_i      (md_result_i)
  );

  // Next-state and registered-output logic; flush overrides every state
  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    strobe_d   = 1'b0;
    clear_d    = 1'b0;
    wbce_d     = 1'b0;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cache_upd  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (issue_valid_i && !flush_i) begin
          funct3_d = funct3_i;
          rd_d     = rd_i;
          op1_d    = rs1_val_i;
          op2_d    = rs2_val_i;
          if (rd_i == 5'd0) begin
            // writes to x0 are architecturally void: drop silently
            state_d = ST_IDLE;
          end else if (cache_hit) begin
            wb_data_d  = cache_data;
            wb_valid_d = 1'b1;
            state_d    = ST_WRITE;
          end else begin
            strobe_d = 1'b1;
            state_d  = ST_LAUNCH;
          end
        end
      end

      ST_LAUNCH: begin
        if (flush_i) begin
          clear_d    = 1'b1;
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (flush_i) begin
          // a result arriving together with the flush is discarded
          clear_d    = 1'b1;
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (md_data_ready_i) begin
          wb_data_d  = md_result_i;
          wb_valid_d = 1'b1;
          wbce_d     = 1'b1;
          cache_upd  = 1'b1;
          state_d    = ST_WRITE;
        end else if (cnt_inc == TIMEOUT_C) begin
          // abort: write zero, flag the error, reset the unit, keep cache
          wb_data_d  = '0;
          wb_valid_d = 1'b1;
          err_d      = 1'b1;
          clear_d    = 1'b1;
          state_d    = ST_WRITE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WRITE: begin
        if (flush_i || wb_ack_i) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        wb_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched instruction, registered outputs and timeout counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      funct3_q   <= '0;
      rd_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      strobe_q   <= 1'b0;
      clear_q    <= 1'b0;
      wbce_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      strobe_q   <= strobe_d;
      clear_q    <= clear_d;
      wbce_q     <= wbce_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign issue_ready_o     = (state_q == ST_IDLE);
  assign stall_o           = (state_q != ST_IDLE);
  assign md_operation_o    = funct3_q;
  assign md_operand1_o     = op1_q;
  assign md_operand2_o     = op2_q;
  assign md_data_ready_o   = strobe_q;
  assign md_clear_o        = clear_q;
  assign md_writeback_ce_o = wbce_q;
  assign wb_valid_o        = wb_valid_q;
  assign wb_rd_o           = rd_q;
  assign wb_data_o         = wb_data_q;
  assign err_o             = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32im_muldiv_issue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rv32im_muldiv_issue
// Description : Directed bench for rv32im_muldiv_issue. The bench plays the
//               muldiv unit; expected write-backs go into a scoreboard queue
//               and a negedge monitor checks each accepted write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32im_muldiv_issue;
  import rv32im_pkg::*;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [2:0]      funct3_i;
  logic [4:0]      rd_i;
  logic [XLEN-1:0] rs1_val_i, rs2_val_i;
  logic            flush_i;
  logic [2:0]      md_operation_o;
  logic [XLEN-1:0] md_operand1_o, md_operand2_o;
  logic            md_data_ready_o, md_clear_o, md_writeback_ce_o;
  logic [XLEN-1:0] md_result_i;
  logic            md_data_ready_i;
  logic            wb_valid_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic            wb_ack_i;
  logic            stall_o, err_o;

  always #5 clk_i = ~clk_i;

  rv32im_muldiv_issue #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .funct3_i          (funct3_i),
    .rd_i              (rd_i),
    .rs1_val_i         (rs1_val_i),
    .rs2_val_i         (rs2_val_i),
    .flush_i           (flush_i),
    .md_operation_o    (md_operation_o),
    .md_operand1_o     (md_operand1_o),
    .md_operand2_o     (md_operand2_o),
    .md_data_ready_o   (md_data_ready_o),
    .md_clear_o        (md_clear_o),
    .md_writeback_ce_o (md_writeback_ce_o),
    .md_result_i       (md_result_i),
    .md_data_ready_i   (md_data_ready_i),
    .wb_valid_o        (wb_valid_o),
    .wb_rd_o           (wb_rd_o),
    .wb_data_o         (wb_data_o),
    .wb_ack_i          (wb_ack_i),
    .stall_o           (stall_o),
    .err_o             (err_o)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  strobe_cnt = 0, wbce_cnt = 0, clear_cnt = 0;
  int  s0, w0, c0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // present one instruction for one cycle; returns in the cycle after accept
  task automatic issue(input logic [2:0] f3, input logic [4:0] rd,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    issue_valid_i = 1'b1;
    funct3_i      = f3;
    rd_i          = rd;
    rs1_val_i     = a;
    rs2_val_i     = b;
    tick();
    issue_valid_i = 1'b0;
  endtask

  // act as muldiv: present a result for one cycle
  task automatic respond(input logic [XLEN-1:0] res);
    md_data_ready_i = 1'b1;
    md_result_i     = res;
    tick();
    md_data_ready_i = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [XLEN-1:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: count pulses and check every accepted register-file write
  always @(negedge clk_i) begin
    wb_t e;
    if (md_data_ready_o)   strobe_cnt++;
    if (md_writeback_ce_o) wbce_cnt++;
    if (md_clear_o)        clear_cnt++;
    if (wb_valid_o && wb_ack_i) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h, expected no write", wb_rd_o, wb_data_o);
      end else begin
        e = sb_q.pop_front();
        chk("wb_rd", 96'(wb_rd_o), 96'(e.rd));
        chk("wb_data", 96'(wb_data_o), 96'(e.data));
      end
    end
  end

  initial begin
    reset_i         = 1'b1;
    issue_valid_i   = 1'b0;
    funct3_i        = '0;
    rd_i            = '0;
    rs1_val_i       = '0;
    rs2_val_i       = '0;
    flush_i         = 1'b0;
    md_result_i     = '0;
    md_data_ready_i = 1'b0;
    wb_ack_i        = 1'b1;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_ctrl", 96'({issue_ready_o, stall_o, md_data_ready_o, md_clear_o,
                           md_writeback_ce_o, wb_valid_o, err_o}), 96'(7'b1000000));
    chk("reset_data", 96'({wb_rd_o, wb_data_o}), 96'(0));
    reset_i = 1'b0;
    tick();

    // DIVU 100/7 -> 14 on rd 5
    s0 = strobe_cnt; w0 = wbce_cnt;
    push(5'd5, 32'd14);
    issue(DIVU, 5'd5, 32'd100, 32'd7);
    chk("t1_launch", 96'({md_data_ready_o, issue_ready_o, stall_o}), 96'(3'b101));
    chk("t1_op", 96'({md_operation_o, md_operand1_o, md_operand2_o}),
        96'({DIVU, 32'd100, 32'd7}));
    tick();
    chk("t1_strobe_off", 96'(md_data_ready_o), 96'(0));
    respond(32'd14);
    chk("t1_write", 96'({wb_valid_o, wb_rd_o, wb_data_o, md_writeback_ce_o}),
        96'({1'b1, 5'd5, 32'd14, 1'b1}));
    tick();
    chk("t1_idle", 96'({wb_valid_o, md_writeback_ce_o, issue_ready_o}), 96'(3'b001));
    chk("t1_strobes", 96'(strobe_cnt - s0), 96'(1));
    chk("t1_wbce", 96'(wbce_cnt - w0), 96'(1));

    // REM -7 % 2 = -1, then identical REM served from cache
    push(5'd6, 32'hFFFF_FFFF);
    issue(REM, 5'd6, 32'hFFFF_FFF9, 32'd2);
    tick();
    respond(32'hFFFF_FFFF);
    tick();
    s0 = strobe_cnt; w0 = wbce_cnt;
    push(5'd7, 32'hFFFF_FFFF);
    issue(REM, 5'd7, 32'hFFFF_FFF9, 32'd2);
    chk("t2_hit", 96'({wb_valid_o, wb_rd_o, wb_data_o, md_data_ready_o}),
        96'({1'b1, 5'd7, 32'hFFFF_FFFF, 1'b0}));
    tick();
    chk("t2_no_strobe", 96'(strobe_cnt - s0), 96'(0));
    chk("t2_no_wbce", 96'(wbce_cnt - w0), 96'(0));

    // MUL to x0 is dropped
    s0 = strobe_cnt;
    issue(MUL, 5'd0, 32'd3, 32'd4);
    chk("t3_drop", 96'({issue_ready_o, stall_o, md_data_ready_o, wb_valid_o}), 96'(4'b1000));
    tick();
    chk("t3_drop2", 96'({issue_ready_o, wb_valid_o}), 96'(2'b10));
    chk("t3_no_strobe", 96'(strobe_cnt - s0), 96'(0));

    // flush in the third WAIT cycle; a late result is ignored
    s0 = strobe_cnt; c0 = clear_cnt;
    issue(MULHU, 5'd8, 32'h8000_0000, 32'd2);
    tick();
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t4_flush", 96'({issue_ready_o, stall_o, md_clear_o, wb_valid_o}), 96'(4'b1010));
    respond(32'd1);
    chk("t4_after", 96'({wb_valid_o, md_clear_o, issue_ready_o, md_writeback_ce_o}), 96'(4'b0010));
    tick();
    chk("t4_no_wb", 96'(wb_valid_o), 96'(0));
    chk("t4_clears", 96'(clear_cnt - c0), 96'(1));
    chk("t4_strobes", 96'(strobe_cnt - s0), 96'(1));

    // write-back held while ack is delayed three cycles
    wb_ack_i = 1'b0;
    push(5'd9, 32'd42);
    issue(MUL, 5'd9, 32'd6, 32'd7);
    tick();
    respond(32'd42);
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold", 96'({wb_valid_o, wb_rd_o, wb_data_o, issue_ready_o}),
          96'({1'b1, 5'd9, 32'd42, 1'b0}));
      tick();
    end
    chk("t5_hold_last", 96'({wb_valid_o, wb_data_o, issue_ready_o}), 96'({1'b1, 32'd42, 1'b0}));
    wb_ack_i = 1'b1;
    tick();
    chk("t5_done", 96'({wb_valid_o, issue_ready_o}), 96'(2'b01));

    // timeout after TO WAIT cycles with no response
    c0 = clear_cnt;
    push(5'd10, 32'd0);
    issue(DIV, 5'd10, 32'd5, 32'd0);
    for (int i = 0; i < TO; i++) begin
      tick();
      chk("t6_wait", 96'({stall_o, wb_valid_o, md_clear_o, err_o}), 96'(4'b1000));
    end
    tick();
    chk("t6_abort", 96'({wb_valid_o, wb_data_o, md_clear_o, err_o, md_writeback_ce_o}),
        96'({1'b1, 32'd0, 1'b1, 1'b1, 1'b0}));
    tick();
    chk("t6_idle", 96'({wb_valid_o, md_clear_o, err_o, issue_ready_o}), 96'(4'b0011));
    tick();
    chk("t6_sticky", 96'(err_o), 96'(1));
    chk("t6_clears", 96'(clear_cnt - c0), 96'(1));

    // timed-out operation was not cached: reissue must launch
    s0 = strobe_cnt;
    push(5'd11, 32'hFFFF_FFFF);
    issue(DIV, 5'd11, 32'd5, 32'd0);
    chk("t6_miss", 96'(md_data_ready_o), 96'(1));
    tick();
    respond(32'hFFFF_FFFF);
    tick();
    chk("t6_strobes", 96'(strobe_cnt - s0), 96'(1));

    // asynchronous reset in the middle of WAIT
    issue(MULHSU, 5'd12, 32'hFFFF_FFFF, 32'd3);
    tick();
    #2 reset_i = 1'b1;
    #1;
    chk("t7_reset_ctrl", 96'({issue_ready_o, stall_o, md_data_ready_o, md_clear_o,
                              md_writeback_ce_o, wb_valid_o, err_o}), 96'(7'b1000000));
    chk("t7_reset_md", 96'({md_operation_o, md_operand1_o, md_operand2_o}), 96'(0));
    chk("t7_reset_wb", 96'({wb_rd_o, wb_data_o}), 96'(0));
    tick();
    reset_i = 1'b0;
    tick();

    // cache was invalidated by reset: the last cached op must launch again
    s0 = strobe_cnt;
    push(5'd13, 32'hFFFF_FFFF);
    issue(DIV, 5'd13, 32'd5, 32'd0);
    chk("t7_miss", 96'(md_data_ready_o), 96'(1));
    tick();
    respond(32'hFFFF_FFFF);
    tick();
    chk("t7_strobes", 96'(strobe_cnt - s0), 96'(1));

    tick();
    chk("sb_empty", 96'(sb_q.size()), 96'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
